// File: rtl/count_history_display_if.sv
// Display-stage bus: the counter strobe coming in and the display pins going out.
interface count_history_display_if;
  logic       in_valid;
  logic [3:0] in_value;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] wrap_cnt;

  // Producer side: drives the strobe, observes the display pins.
  modport master (
    output in_valid, in_value,
    input  an, seg, dp, wrap_cnt
  );

  // Display block side.
  modport slave (
    input  in_valid, in_value,
    output an, seg, dp, wrap_cnt
  );
endinterface

// File: rtl/count_history_display.sv
// Captures strobed counter values into a three-deep history, counts wraps,
// and scans history plus wrap count onto a 4-digit common-anode display.
module count_history_display #(
  parameter int SCAN_W = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  count_history_display_if.slave      bus
);

  logic [3:0]        h0_q, h1_q, h2_q;
  logic [3:0]        h0_d, h1_d, h2_d;
  logic [3:0]        wrap_q, wrap_d;
  logic [SCAN_W-1:0] div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        digit;

  // Active-low hex decoder, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next-state for history, wrap counter and scan position.
  always_comb begin
    h0_d   = h0_q;
    h1_d   = h1_q;
    h2_d   = h2_q;
    wrap_d = wrap_q;
    if (bus.in_valid) begin
      h2_d = h1_q;
      h1_d = h0_q;
      h0_d = bus.in_value;
      // A smaller value than the previous newest sample means the counter rolled over.
      if (bus.in_value < h0_q) wrap_d = wrap_q + 4'd1;
    end
    div_d = div_q + 1'b1;
    idx_d = (&div_q) ? idx_q + 2'd1 : idx_q;
  end

  // Output stage works from the current registers, so pins lag idx/history by one cycle.
  always_comb begin
    case (idx_q)
      2'd0:    digit = h0_q;
      2'd1:    digit = h1_q;
      2'd2:    digit = h2_q;
      default: digit = wrap_q;
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = hex_to_seg(digit);
    dp_d  = (idx_q != 2'd3);
  end

  // State and output registers; reset blanks the display and drops any in-flight sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h0_q   <= '0;
      h1_q   <= '0;
      h2_q   <= '0;
      wrap_q <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      h0_q   <= h0_d;
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      wrap_q <= wrap_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.wrap_cnt = wrap_q;

endmodule

// File: tb/tb_count_history_display.sv
// Scoreboard bench: the driver predicts each cycle's pins from a behavioural
// model and queues them; the monitor pops and compares after every edge.
module tb_count_history_display;
  localparam int SCAN_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  count_history_display_if bus();

  count_history_display #(.SCAN_W(SCAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] wrap;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state.
  logic [6:0] seg_tab [16];
  int   hist[$];          // hist[0] is newest
  int   wraps;
  int   steps;            // clock edges since the last reset
  string cur_tag;

  function automatic int cur_idx();
    return (steps / (1 << SCAN_W)) % 4;
  endfunction

  // Drive one cycle and queue the pins expected right after its edge.
  task automatic cycle(input logic rst, input logic v, input int val);
    exp_t e;
    int idx, d;
    @(negedge clk);
    rst_n = rst;
    bus.in_valid = v;
    bus.in_value = val[3:0];
    e.tag = cur_tag;
    if (!rst) begin
      e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.wrap = 4'd0;
      hist = '{0, 0, 0};
      wraps = 0;
      steps = 0;
    end else begin
      idx = cur_idx();
      d = (idx == 3) ? wraps : hist[idx];
      e.an = 4'b1111;
      e.an[idx] = 1'b0;
      e.seg = seg_tab[d];
      e.dp = (idx == 3) ? 1'b0 : 1'b1;
      if (v) begin
        if (val < hist[0]) wraps = (wraps + 1) % 16;
        hist.push_front(val);
        void'(hist.pop_back());
      end
      e.wrap = wraps[3:0];
      steps++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare every cycle's pins against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp || bus.wrap_cnt !== e.wrap) begin
          miscompares++;
          $display("FAIL %s: got an=%b seg=%b dp=%b wrap=%0d, want an=%b seg=%b dp=%b wrap=%0d",
                   e.tag, bus.an, bus.seg, bus.dp, bus.wrap_cnt, e.an, e.seg, e.dp, e.wrap);
        end
      end
    end
  end

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    hist = '{0, 0, 0};
    wraps = 0;
    steps = 0;
    bus.in_valid = 1'b0;
    bus.in_value = 4'd0;

    // Reset: strobes during reset must be ignored.
    cur_tag = "reset";
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 7 - i);

    cur_tag = "scan";
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 0);

    cur_tag = "history";
    cycle(1'b1, 1'b1, 5);
    cycle(1'b1, 1'b1, 6);
    cycle(1'b1, 1'b1, 7);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 0);

    // Full count stream to 16 wraps, so the counter rolls back to 0.
    cur_tag = "wraps";
    for (int r = 0; r < 16; r++)
      for (int v = 0; v < 8; v++) cycle(1'b1, 1'b1, v);
    cycle(1'b1, 1'b1, 0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 0);

    cur_tag = "nonwrap";
    cycle(1'b1, 1'b1, 3);
    cycle(1'b1, 1'b1, 3);
    cycle(1'b1, 1'b1, 2);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 0);

    // Reset landing on a strobe while digit 2 is selected.
    cur_tag = "midreset";
    for (int i = 0; i < 16 && cur_idx() != 2; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 4);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);

    cur_tag = "random";
    for (int i = 0; i < 400; i++) begin
      logic r, v;
      int val;
      r = ($urandom_range(0, 63) != 0);
      v = ($urandom_range(0, 1) == 1);
      val = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      cycle(r, v, val);
    end

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
